// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// sdram_pkg : shared SDRAM command codes, burst geometry and read-FSM states
// Rev 1.0
// ============================================================================
package sdram_pkg;

  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_PRECH  = 4'b0010;

  localparam int BURST_LEN   = 4;
  localparam int BURST_TIMES = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_TRIG = 3'b010,
    S_WAIT = 3'b100
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_fifo_fwft.sv
`default_nettype none
// ============================================================================
// sdram_fifo_fwft : first-word-fall-through FIFO with sticky overflow flag
// Rev 1.0
// ============================================================================
module sdram_fifo_fwft #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop_ready,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign pop     = pop_ready && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign dout       = empty ? '0 : mem[rd_ptr];
  assign dout_valid = !empty;
  assign fill_level = count;

endmodule
`default_nettype wire

// File: rtl/sdram_rd_buffer.sv
`default_nettype none
// ============================================================================
// sdram_rd_buffer : captures SDRAM read data into a FWFT FIFO and paces read_trig
// Rev 1.0
// ============================================================================
module sdram_rd_buffer
  import sdram_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 16,
  parameter int WORDS_PER_TRIG = BURST_LEN * BURST_TIMES,
  parameter int TRIG_HOLD      = 4,
  parameter int TIMEOUT        = 1023
) (
  input  logic                     sysclk_100M,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        sdram_dq,
  input  logic                     data_vld,
  input  logic                     read_end,
  input  logic                     rd_en,
  output logic                     read_trig,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int FW = $clog2(DEPTH) + 2;
  localparam int TW = $clog2(TRIG_HOLD);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic signed [FW-1:0] NEED      = FW'(WORDS_PER_TRIG);
  localparam logic        [TW-1:0] TRIG_LAST = TW'(TRIG_HOLD - 1);
  localparam logic        [CW-1:0] WAIT_LAST = CW'(TIMEOUT);

  rd_state_t             state;
  logic [TW-1:0]         trig_cnt;
  logic [CW-1:0]         wait_cnt;
  logic [LW-1:0]         inflight;
  logic signed [FW-1:0]  free;
  logic                  start;
  logic                  timeout_hit;

  sdram_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (sysclk_100M),
    .rst_n      (rst_n),
    .push       (data_vld),
    .din        (sdram_dq),
    .pop_ready  (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .fill_level (fill_level),
    .overflow   (overflow)
  );

  // Words already promised by the engine count against free space, so a new
  // trigger is only issued when the whole transaction is guaranteed to fit.
  assign free        = FW'(DEPTH) - FW'(fill_level) - FW'(inflight);
  assign start       = (state == S_IDLE) && rd_en && (free >= NEED);
  assign timeout_hit = (state == S_WAIT) && !read_end && (wait_cnt == WAIT_LAST);

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (start) begin
      inflight <= LW'(WORDS_PER_TRIG);
    end else if (read_end || timeout_hit) begin
      inflight <= '0;
    end else if (data_vld && inflight != '0) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      read_trig   <= 1'b0;
      trig_cnt    <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_TRIG;
            read_trig <= 1'b1;
            trig_cnt  <= '0;
          end
        end
        S_TRIG: begin
          // Held for TRIG_HOLD cycles so the engine's 2-FF edge detector sees it.
          if (trig_cnt == TRIG_LAST) begin
            state     <= S_WAIT;
            read_trig <= 1'b0;
            wait_cnt  <= '0;
          end else begin
            trig_cnt <= trig_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (read_end) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          read_trig <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sdram_rd_buffer.md
Name: sdram_rd_buffer

Overview:
- Downstream consumer of the SDRAM read engine.
- Captures the SDRAM DQ word on every cycle the read engine flags data_vld, and stores it in a first-word-fall-through FIFO.
- Presents the stored data to the user side over a valid/ready handshake.
- Generates the engine's read_trig only when the FIFO has room for a full transaction, and tracks completion through the engine's read_end pulse.

Parameters:
- DATA_W, 16: SDRAM DQ / user data width.
- DEPTH, 16: FIFO depth in words; power of 2, must be ≥ WORDS_PER_TRIG.
- WORDS_PER_TRIG, 4: words one read_trig produces (burst length 4 × 1 burst).
- TRIG_HOLD, 4: cycles read_trig is held high; must be ≥ 3 for the engine's 2-FF edge detector.
- TIMEOUT, 1023: maximum cycles in WAIT without seeing read_end.

Ports:
- sysclk_100M, in, 1: system clock, 100 MHz.
- rst_n, in, 1: asynchronous active-low reset.
- sdram_dq, in, DATA_W: SDRAM read data, registered externally to align with data_vld.
- data_vld, in, 1: from read engine; sdram_dq is valid this cycle.
- read_end, in, 1: from read engine; one-cycle pulse when the transaction completes.
- rd_en, in, 1: user enable for continuous prefetch.
- read_trig, out, 1: to read engine; level pulse that starts one transaction.
- dout, out, DATA_W: FIFO head word.
- dout_valid, out, 1: FIFO non-empty.
- dout_ready, in, 1: user accepts dout.
- fill_level, out, $clog2(DEPTH)+1: words currently stored.
- overflow, out, 1: sticky; a word was dropped because the FIFO was full.
- timeout_err, out, 1: sticky; read_end did not arrive within TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers, fill_level, inflight, and all counters go to 0.
  - FSM goes to S_IDLE.
  - read_trig, dout_valid, overflow, and timeout_err go to 0. dout goes to 0.
- Capture:
  - Every cycle data_vld=1 pushes sdram_dq.
  - Latency from push to dout_valid is 1 cycle when the FIFO was empty.
- Pop:
  - A pop occurs when dout_valid && dout_ready.
  - dout updates to the next word in the following cycle (FWFT).
- Push and pop in the same cycle:
  - Both take effect and fill_level is unchanged.
  - When full, a simultaneous pop frees the slot, so the push is accepted.
- Push while full with no pop: the word is dropped, pointers are unchanged, and overflow is set until reset.
- Pop while empty: impossible by the handshake; dout_ready is ignored.
- Pointers: log2(DEPTH) bits, natural wrap-around. Full/empty are derived from fill_level (0 / DEPTH).
- inflight counter:
  - Loaded with WORDS_PER_TRIG on the S_IDLE→S_TRIG transition.
  - Decremented on each captured push, saturating at 0.
  - Cleared on read_end.
- Free space = DEPTH − fill_level − inflight.
- FSM states:
  - S_IDLE: read_trig=0. When rd_en && free ≥ WORDS_PER_TRIG, go to S_TRIG.
  - S_TRIG: read_trig=1 for exactly TRIG_HOLD cycles (trig_cnt). Then go to S_WAIT.
  - S_WAIT: read_trig=0 and wait_cnt increments.
    - read_end=1 → S_IDLE, wait_cnt=0.
    - wait_cnt==TIMEOUT → set timeout_err, clear inflight, go to S_IDLE.
- read_end arriving in S_TRIG or S_IDLE is ignored for state purposes but still clears inflight.
- Deasserting rd_en mid-transaction does not abort it; the FSM completes to S_IDLE and then stops issuing.
- Back-to-back transactions: minimum gap from read_end to the next read_trig rise is 1 cycle (S_WAIT→S_IDLE→S_TRIG).
- data_vld while in S_IDLE (stray data) is still captured; inflight stays 0.
- Widths: fill_level holds 0..DEPTH inclusive. Free-space arithmetic uses $clog2(DEPTH)+2 bits, signed-safe, with no underflow.

Decomposition:
- Shared package sdram_pkg holds:
  - SDRAM command encodings (READ 4'b0101, ACTIVE 4'b0011, NOP 4'b0111, PRECH 4'b0010).
  - Burst length 4 and BURST_TIMES.
  - One-hot state constants for this FSM (S_IDLE/S_TRIG/S_WAIT).
- Sub-module sdram_fifo_fwft holds the DATA_W×DEPTH storage, pointers, fill_level, and overflow. It is reused by the write path.
- The top level keeps the trigger FSM, inflight, and timeout.

Test Plan:
- Reset, then rd_en=1, dout_ready=0, with an engine model returning 4 words 0xA001..0xA004 then read_end → read_trig high 4 cycles; fill_level 0→4; dout=0xA001 with dout_valid=1; next trig issued (free=12).
- DEPTH=16, dout_ready=0 held → exactly 4 triggers issued; fill_level=16; no 5th read_trig; overflow=0.
- From full, pop 4 words with dout_ready=1 → free reaches 4 and read_trig re-asserts; output order is 0xA001,0xA002,… with no gaps or duplicates.
- Force data_vld for 5 words while fill_level=15 and dout_ready=0 → 1 accepted, 4 dropped; fill_level=16; overflow=1 until reset.
- Engine model never pulses read_end → after TIMEOUT (1023) cycles in S_WAIT: timeout_err=1, inflight=0, FSM back to S_IDLE, new read_trig issued.
- Assert rst_n=0 mid-S_TRIG with fill_level=7 → read_trig=0, fill_level=0, dout_valid=0 immediately (async); normal operation resumes after release.
